// File: rtl/exec_sequencer.sv
// Eight-phase nibble-serial instruction sequencer: fetches 1/2-byte instructions
// from a 4-bit ROM bus, drives an external ALU and executes a small opcode subset.
module exec_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [3:0]  romData,
  output logic [3:0]  romAddr,
  output logic        syncOut,
  output logic [2:0]  phaseOut,
  output logic [3:0]  aluOp,
  output logic [3:0]  aluAcc,
  output logic [3:0]  aluOpa,
  output logic        aluCarryIn,
  input  logic [3:0]  aluResult,
  input  logic        aluCarryOut,
  input  logic        aluZero,
  output logic [3:0]  accOut,
  output logic        carryFlag,
  output logic        zeroFlag,
  output logic [11:0] pcOut,
  output logic        secondCycle
);

  typedef enum logic [2:0] {
    PH_A1 = 3'd0,
    PH_A2 = 3'd1,
    PH_A3 = 3'd2,
    PH_M1 = 3'd3,
    PH_M2 = 3'd4,
    PH_X1 = 3'd5,
    PH_X2 = 3'd6,
    PH_X3 = 3'd7
  } phase_e;

  phase_e      phase_q, phase_d;
  logic [11:0] pc_q, pc_d;
  logic [7:0]  ir_q, ir_d;
  logic [7:0]  ir2_q, ir2_d;
  logic [3:0]  acc_q, acc_d;
  logic        carry_q, carry_d;
  logic        zero_q, zero_d;
  logic        second_q, second_d;
  logic [3:0]  regs_q [16];
  logic [3:0]  regs_d [16];

  logic [3:0]  opc;
  logic [3:0]  idx;
  logic [3:0]  rsel;
  logic        two_byte;

  assign opc  = ir_q[7:4];
  assign idx  = ir_q[3:0];
  assign rsel = regs_q[idx];
  assign two_byte = (opc == 4'h1) || (opc == 4'h4) || (opc == 4'h5) || (opc == 4'h7) ||
                    ((opc == 4'h2) && !ir_q[0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q  <= PH_A1;
      pc_q     <= '0;
      ir_q     <= '0;
      ir2_q    <= '0;
      acc_q    <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b1;
      second_q <= 1'b0;
      for (int unsigned i = 0; i < 16; i++) regs_q[i] <= '0;
    end else begin
      phase_q  <= phase_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      ir2_q    <= ir2_d;
      acc_q    <= acc_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      second_q <= second_d;
      for (int unsigned i = 0; i < 16; i++) regs_q[i] <= regs_d[i];
    end
  end

  always_comb begin
    phase_d  = phase_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    ir2_d    = ir2_q;
    acc_d    = acc_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    second_d = second_q;
    for (int unsigned i = 0; i < 16; i++) regs_d[i] = regs_q[i];

    aluOp  = '0;
    aluOpa = '0;
    // ALU is only engaged during the execute phase of a first cycle
    if (phase_q == PH_X2 && !second_q) begin
      unique case (opc)
        4'h8, 4'h9: begin aluOp = opc;   aluOpa = rsel; end
        4'hD:       begin aluOp = 4'hD;  aluOpa = idx;  end
        default:    ;
      endcase
    end

    if (en) begin
      phase_d = phase_e'(phase_q + 3'd1);
      unique case (phase_q)
        PH_M1: begin
          if (second_q) ir2_d[7:4] = romData;
          else          ir_d[7:4]  = romData;
        end
        PH_M2: begin
          if (second_q) ir2_d[3:0] = romData;
          else          ir_d[3:0]  = romData;
          pc_d = pc_q + 12'd1;
        end
        PH_X2: begin
          if (!second_q) begin
            unique case (opc)
              4'h8, 4'h9, 4'hD: begin
                acc_d   = aluResult;
                carry_d = aluCarryOut;
                zero_d  = aluZero;
              end
              4'hA: begin
                acc_d  = rsel;
                zero_d = (rsel == 4'h0);
              end
              4'hB: begin
                acc_d       = rsel;
                regs_d[idx] = acc_q;
                zero_d      = (rsel == 4'h0);
              end
              4'hF: begin
                unique case (idx)
                  4'h0: begin acc_d = '0; carry_d = 1'b0; zero_d = 1'b1; end
                  4'h1: carry_d = 1'b0;
                  4'h3: carry_d = ~carry_q;
                  4'hA: carry_d = 1'b1;
                  default: ;
                endcase
              end
              default: ;
            endcase
          end
        end
        PH_X3: begin
          if (second_q) begin
            second_d = 1'b0;
            if (opc == 4'h4) pc_d = {idx, ir2_q};
          end else if (two_byte) begin
            second_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    unique case (phase_q)
      PH_A1:   romAddr = pc_q[3:0];
      PH_A2:   romAddr = pc_q[7:4];
      PH_A3:   romAddr = pc_q[11:8];
      default: romAddr = '0;
    endcase
  end

  assign syncOut     = (phase_q == PH_A1);
  assign phaseOut    = phase_q;
  assign aluAcc      = acc_q;
  assign aluCarryIn  = carry_q;
  assign accOut      = acc_q;
  assign carryFlag   = carry_q;
  assign zeroFlag    = zero_q;
  assign pcOut       = pc_q;
  assign secondCycle = second_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// Bench for exec_sequencer: ROM and ALU environment, machine-cycle-level reference
// model, directed table/sequences and randomized run.
module tb_exec_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [3:0]  romData;
  logic [3:0]  romAddr;
  logic        syncOut;
  logic [2:0]  phaseOut;
  logic [3:0]  aluOp, aluAcc, aluOpa;
  logic        aluCarryIn;
  logic [3:0]  aluResult;
  logic        aluCarryOut, aluZero;
  logic [3:0]  accOut;
  logic        carryFlag, zeroFlag;
  logic [11:0] pcOut;
  logic        secondCycle;

  exec_sequencer dut (
    .clk(clk), .rst(rst), .en(en), .romData(romData), .romAddr(romAddr),
    .syncOut(syncOut), .phaseOut(phaseOut), .aluOp(aluOp), .aluAcc(aluAcc),
    .aluOpa(aluOpa), .aluCarryIn(aluCarryIn), .aluResult(aluResult),
    .aluCarryOut(aluCarryOut), .aluZero(aluZero), .accOut(accOut),
    .carryFlag(carryFlag), .zeroFlag(zeroFlag), .pcOut(pcOut),
    .secondCycle(secondCycle)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0]  rom [4096];
  int          bph;
  logic [11:0] mpc;
  logic [7:0]  mir;
  logic        msec;
  logic [3:0]  macc;
  logic        mcarry, mzero;
  logic [3:0]  mregs [16];
  logic        junk;
  logic [7:0]  cur;
  logic [3:0]  rd;

  // returns {zero, carry_out, result}
  function automatic logic [5:0] alu(input logic [3:0] op, input logic [3:0] a,
                                     input logic [3:0] b, input logic c);
    logic [4:0] s;
    case (op)
      4'h8:    s = {1'b0, a} + {1'b0, b} + {4'b0, c};
      4'h9:    s = {1'b0, a} - {1'b0, b} - {4'b0, c};
      4'hD:    s = {c, b};
      default: s = {c, a};
    endcase
    return {s[3:0] == 4'h0, s};
  endfunction

  always_comb {aluZero, aluCarryOut, aluResult} = alu(aluOp, aluAcc, aluOpa, aluCarryIn);

  always_comb begin
    cur = rom[mpc];
    case (bph)
      3:       rd = cur[7:4];
      4:       rd = cur[3:0];
      default: rd = 4'h5;
    endcase
    romData = junk ? ~rd : rd;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    bph = 0; mpc = '0; mir = '0; msec = 1'b0;
    macc = '0; mcarry = 1'b0; mzero = 1'b1;
    for (int i = 0; i < 16; i++) mregs[i] = '0;
  endtask

  task automatic model_exec(input logic [7:0] b);
    logic [3:0] op, ix, t;
    logic [5:0] r;
    op = b[7:4]; ix = b[3:0];
    case (op)
      4'h8, 4'h9, 4'hD: begin
        r = alu(op, macc, (op == 4'hD) ? ix : mregs[ix], mcarry);
        macc = r[3:0]; mcarry = r[4]; mzero = r[5];
      end
      4'hA: begin macc = mregs[ix]; mzero = (macc == 0); end
      4'hB: begin t = macc; macc = mregs[ix]; mregs[ix] = t; mzero = (macc == 0); end
      4'hF: begin
        if (ix == 4'h0) begin macc = 0; mcarry = 0; mzero = 1; end
        else if (ix == 4'h1) mcarry = 0;
        else if (ix == 4'h3) mcarry = ~mcarry;
        else if (ix == 4'hA) mcarry = 1;
      end
      default: ;
    endcase
  endtask

  // One whole 8-phase machine cycle in a single step
  task automatic machine_cycle();
    logic [7:0] b;
    b = rom[mpc];
    mpc = mpc + 12'd1;
    if (!msec) begin
      mir = b;
      model_exec(b);
      if (b[7:4] inside {4'h1, 4'h4, 4'h5, 4'h7} || (b[7:4] == 4'h2 && !b[0])) msec = 1;
    end else begin
      msec = 0;
      if (mir[7:4] == 4'h4) mpc = {mir[3:0], b};
    end
  endtask

  task automatic check_cycle();
    logic [7:0] ins;
    logic [3:0] eop, eopa, ea;
    chk("phase", phaseOut, bph[2:0]);
    chk("sync", syncOut, bph == 0);
    case (bph)
      0: ea = mpc[3:0];
      1: ea = mpc[7:4];
      2: ea = mpc[11:8];
      default: ea = 4'h0;
    endcase
    chk("romaddr", romAddr, ea);
    ins = rom[mpc];
    eop = 4'h0; eopa = 4'h0;
    if (bph == 6 && !msec) begin
      if (ins[7:4] == 4'h8 || ins[7:4] == 4'h9) begin eop = ins[7:4]; eopa = mregs[ins[3:0]]; end
      else if (ins[7:4] == 4'hD) begin eop = 4'hD; eopa = ins[3:0]; end
    end
    chk("aluop", aluOp, eop);
    chk("aluopa", aluOpa, eopa);
    if (bph == 0) begin
      chk("acc", accOut, macc);
      chk("carry", carryFlag, mcarry);
      chk("zero", zeroFlag, mzero);
      chk("pc", pcOut, mpc);
      chk("second", secondCycle, msec);
      chk("aluacc", aluAcc, macc);
      chk("alucin", aluCarryIn, mcarry);
    end
  endtask

  task automatic step(input logic e);
    en = e;
    @(posedge clk);
    #1;
    if (e) begin
      bph = (bph + 1) % 8;
      if (bph == 0) machine_cycle();
    end
    check_cycle();
  endtask

  task automatic do_reset();
    #1 rst = 1'b1;
    #1;
    model_reset();
    chk("rst_phase", phaseOut, 0);
    chk("rst_second", secondCycle, 0);
    chk("rst_pc", pcOut, 0);
    chk("rst_acc", accOut, 0);
    chk("rst_carry", carryFlag, 0);
    chk("rst_zero", zeroFlag, 1);
    chk("rst_romaddr", romAddr, 0);
    chk("rst_sync", syncOut, 1);
    chk("rst_aluop", aluOp, 0);
    #1 rst = 1'b0;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
  endtask

  typedef struct {
    logic [7:0] ins;
    logic [3:0] acc;
    logic       c;
    logic       z;
  } vec_t;

  vec_t tbl [12];

  initial begin
    rst = 1'b1; en = 1'b0; junk = 1'b0;
    clear_rom();
    model_reset();

    tbl[0]  = '{8'hD7, 4'h7, 1'b0, 1'b0};
    tbl[1]  = '{8'hB3, 4'h0, 1'b0, 1'b1};
    tbl[2]  = '{8'hDB, 4'hB, 1'b0, 1'b0};
    tbl[3]  = '{8'hF1, 4'hB, 1'b0, 1'b0};
    tbl[4]  = '{8'h83, 4'h2, 1'b1, 1'b0};
    tbl[5]  = '{8'hFA, 4'h2, 1'b1, 1'b0};
    tbl[6]  = '{8'hF3, 4'h2, 1'b0, 1'b0};
    tbl[7]  = '{8'hA3, 4'h7, 1'b0, 1'b0};
    tbl[8]  = '{8'hF0, 4'h0, 1'b0, 1'b1};
    tbl[9]  = '{8'h93, 4'h9, 1'b1, 1'b0};
    tbl[10] = '{8'hD0, 4'h0, 1'b1, 1'b1};
    tbl[11] = '{8'h21, 4'h0, 1'b1, 1'b1};

    #3;
    do_reset();

    // LDM 5
    rom[0] = 8'hD5;
    for (int i = 0; i < 8; i++) begin
      step(1'b1);
      if (bph == 6) begin
        chk("ldm_aluop", aluOp, 4'hD);
      end else begin
        chk("ldm_aluop_idle", aluOp, 4'h0);
      end
      if (bph == 7) begin
        chk("ldm_acc", accOut, 4'h5);
        chk("ldm_carry", carryFlag, 0);
        chk("ldm_zero", zeroFlag, 0);
        chk("ldm_pc", pcOut, 12'h001);
      end
    end

    // single-byte opcode table
    clear_rom();
    for (int i = 0; i < 12; i++) rom[i] = tbl[i].ins;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      for (int k = 0; k < 8; k++) step(1'b1);
      chk("tbl_acc", accOut, tbl[i].acc);
      chk("tbl_carry", carryFlag, tbl[i].c);
      chk("tbl_zero", zeroFlag, tbl[i].z);
      chk("tbl_pc", pcOut, i + 1);
      chk("tbl_second", secondCycle, 0);
    end

    // JUN 0x02A
    clear_rom();
    rom[0] = 8'h40; rom[1] = 8'h2A;
    do_reset();
    for (int k = 0; k < 8; k++) step(1'b1);
    for (int k = 0; k < 8; k++) begin
      chk("jun_second", secondCycle, 1);
      step(1'b1);
    end
    chk("jun_pc", pcOut, 12'h02A);
    chk("jun_second_clr", secondCycle, 0);

    // pc wrap at 0xFFF
    clear_rom();
    rom[0] = 8'h4F; rom[1] = 8'hFF;
    do_reset();
    for (int k = 0; k < 16; k++) step(1'b1);
    chk("wrap_pc_start", pcOut, 12'hFFF);
    for (int k = 0; k < 4; k++) step(1'b1);
    chk("wrap_pc_before", pcOut, 12'hFFF);
    step(1'b1);
    chk("wrap_pc_after", pcOut, 12'h000);
    for (int k = 0; k < 3; k++) step(1'b1);

    // en held low in M1 with a disturbed ROM bus
    clear_rom();
    rom[0] = 8'hD5;
    do_reset();
    for (int k = 0; k < 3; k++) step(1'b1);
    junk = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step(1'b0);
      chk("hold_phase", phaseOut, 3);
      chk("hold_pc", pcOut, 0);
    end
    junk = 1'b0;
    for (int k = 0; k < 5; k++) step(1'b1);
    chk("hold_acc", accOut, 4'h5);
    chk("hold_pc_after", pcOut, 12'h001);

    // reset during second-cycle M2
    clear_rom();
    rom[0] = 8'h40; rom[1] = 8'h2A;
    do_reset();
    for (int k = 0; k < 12; k++) step(1'b1);
    chk("pre_rst_second", secondCycle, 1);
    do_reset();
    for (int k = 0; k < 8; k++) step(1'b1);
    chk("post_rst_pc", pcOut, 12'h001);
    chk("post_rst_second", secondCycle, 1);

    // randomized program with random enable gaps
    for (int i = 0; i < 4096; i++) rom[i] = 8'($urandom);
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      step(($urandom_range(0, 9) != 0) ? 1'b1 : 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
